dmem_responder: RTL and testbench

- Target end of the memory-stage data access: services load/store requests issued by the pipeline's memory stage.
- Configurable wait-state latency, driven by a valid/ready request and one-cycle response handshake.
- Produces the stall the hazard unit uses to freeze the pipeline while an access is outstanding.
- Holds the data word array and exports the low half-word of a fixed test location for board/bench observation.

---
 rtl/dmem_responder.sv | 230 +++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: memory-stage data responder.
// Accepts one load/store at a time through a valid/ready request, waits
// LATENCY cycles, then returns a one-cycle response. Drives the pipeline
// stall while an access is outstanding and exposes the low half-word of
// mem[TEST_ADDR] for observation.
// Optional feature: define DMEM_BYTE_EN_EN to add per-byte store enables
// (req_be[3:0]); without it every store writes the full word.
module dmem_responder #(
    parameter int DEPTH     = 256,
    parameter int LATENCY   = 2,
    parameter int TEST_ADDR = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_EN_EN
    input  logic [3:0]  req_be,
`endif
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        mem_stall,
    output logic        misalign_err,
    output logic [15:0] test_value
);

    localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]      LAT       = 4'(LATENCY);
    localparam logic [AW-1:0]   TEST_IDX  = AW'(TEST_ADDR);
    localparam logic [31:0]     MISAL_PAT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Byte-lane merge: lanes with be=1 take the new data, others keep old.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_w[8*b +: 8];
            end
        end
        return res;
    endfunction

    state_t          state_r;
    state_t          state_next_s;
    logic [3:0]      cnt_r;
    logic            we_r;
    logic [AW-1:0]   idx_r;
    logic [31:0]     wdata_r;
    logic            mis_r;
    logic [3:0]      be_r;
    logic [31:0]     rdata_r;
    logic            misalign_r;
    logic [31:0]     mem_r [DEPTH];

    logic [3:0]      be_s;
    logic [AW-1:0]   req_idx_s;
    logic            req_mis_s;
    logic            accept_s;
    logic            enter_resp_s;
    logic            sel_we_s;
    logic [AW-1:0]   sel_idx_s;
    logic            sel_mis_s;
    logic [31:0]     rdata_next_s;
    logic            wr_en_s;
    logic [31:0]     wr_word_s;
    logic            req_ready_s;
    logic            rsp_valid_s;
    logic            mem_stall_s;
    logic            unused_addr_s;

`ifdef DMEM_BYTE_EN_EN
    assign be_s = req_be;
`else
    assign be_s = 4'b1111;
`endif

    // Upper address bits wrap modulo DEPTH and are deliberately ignored.
    assign unused_addr_s = ^req_addr[31:AW+2];
    assign req_idx_s     = req_addr[AW+1:2];
    assign req_mis_s     = (req_addr[1:0] != 2'b00);
    assign accept_s      = (state_r == ST_IDLE) && req_valid;
    assign enter_resp_s  = (state_next_s == ST_RESP) && (state_r != ST_RESP);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: IDLE -> WAIT/RESP on accept, WAIT counts down, RESP lasts one cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_next_s = (LAT == 4'd0) ? ST_RESP : ST_WAIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd1) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_RESP: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output decode: ready only out of reset in IDLE, stall covers the accept cycle and WAIT.
    always_comb begin
        req_ready_s = 1'b0;
        rsp_valid_s = 1'b0;
        mem_stall_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                req_ready_s = reset;
                mem_stall_s = reset && req_valid;
            end
            ST_WAIT: begin
                mem_stall_s = 1'b1;
            end
            ST_RESP: begin
                rsp_valid_s = 1'b1;
            end
            default: begin
                req_ready_s = 1'b0;
            end
        endcase
    end

    // Response data source: live request fields when entering RESP straight from IDLE, latched otherwise.
    always_comb begin
        sel_we_s  = we_r;
        sel_idx_s = idx_r;
        sel_mis_s = mis_r;
        if (state_r == ST_IDLE) begin
            sel_we_s  = req_we;
            sel_idx_s = req_idx_s;
            sel_mis_s = req_mis_s;
        end else begin
            sel_we_s  = we_r;
            sel_idx_s = idx_r;
            sel_mis_s = mis_r;
        end
        if (sel_mis_s) begin
            rdata_next_s = MISAL_PAT;
        end else if (sel_we_s) begin
            rdata_next_s = 32'd0;
        end else begin
            rdata_next_s = mem_r[sel_idx_s];
        end
    end

    // Store commit on the edge leaving RESP; misaligned stores are suppressed.
    always_comb begin
        wr_en_s   = (state_r == ST_RESP) && we_r && !mis_r;
        wr_word_s = merge_bytes(mem_r[idx_r], wdata_r, be_r);
    end

    // Request latch, wait counter, response data and sticky misalign flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r      <= 4'd0;
            we_r       <= 1'b0;
            idx_r      <= '0;
            wdata_r    <= 32'd0;
            mis_r      <= 1'b0;
            be_r       <= 4'd0;
            rdata_r    <= 32'd0;
            misalign_r <= 1'b0;
        end else begin
            if (accept_s) begin
                cnt_r   <= LAT;
                we_r    <= req_we;
                idx_r   <= req_idx_s;
                wdata_r <= req_wdata;
                mis_r   <= req_mis_s;
                be_r    <= be_s;
            end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
                cnt_r <= cnt_r - 4'd1;
            end
            if (enter_resp_s) begin
                rdata_r <= rdata_next_s;
            end
            if ((state_r == ST_RESP) && mis_r) begin
                misalign_r <= 1'b1;
            end
        end
    end

    // Data array: cleared by reset, written once per store.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'd0;
            end
        end else if (wr_en_s) begin
            mem_r[idx_r] <= wr_word_s;
        end
    end

    assign req_ready    = req_ready_s;
    assign rsp_valid    = rsp_valid_s;
    assign mem_stall    = mem_stall_s;
    assign rsp_rdata    = rdata_r;
    assign misalign_err = misalign_r;
    assign test_value   = mem_r[TEST_IDX][15:0];

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random
// loads/stores compared against a word-array reference model.
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        mem_stall;
    logic        misalign_err;
    logic [15:0] test_value;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] model [256];
    logic        mis_model;

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH(256),
        .LATENCY(LAT),
        .TEST_ADDR(0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
`ifdef DMEM_BYTE_EN_EN
        .req_be(req_be),
`endif
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .mem_stall(mem_stall),
        .misalign_err(misalign_err),
        .test_value(test_value)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) model[i] = 32'd0;
        mis_model = 1'b0;
    endtask

    // One full access; caller is positioned just after a rising edge.
    task automatic access(input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] be);
        int          idx;
        int          cyc;
        int          stalls;
        logic        al;
        logic [3:0]  eff;
        logic [31:0] exp_rd;
        idx = int'(addr[9:2]);
        al  = (addr[1:0] == 2'b00);
`ifdef DMEM_BYTE_EN_EN
        eff = be;
`else
        eff = 4'hF;
`endif
        if (!al)     exp_rd = 32'hDEAD_BEEF;
        else if (we) exp_rd = 32'd0;
        else         exp_rd = model[idx];
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        #1;
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        chk("stall_on_req", {31'd0, mem_stall}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc    = 1;
        stalls = 1;
        while (!rsp_valid && cyc < 40) begin
            if (mem_stall) stalls++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", cyc, LAT + 1);
        chk("stall_cycles", stalls, LAT + 1);
        chk("stall_in_resp", {31'd0, mem_stall}, 32'd0);
        chk("ready_in_resp", {31'd0, req_ready}, 32'd0);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        if (we && al) begin
            for (int b = 0; b < 4; b++)
                if (eff[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
        end
        if (!al) mis_model = 1'b1;
        @(posedge clk); #1;
        chk("rsp_pulse_end", {31'd0, rsp_valid}, 32'd0);
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, mis_model});
        chk("test_value", {16'd0, test_value}, {16'd0, model[0][15:0]});
    endtask

    initial begin
        logic [31:0] a;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_be    = 4'hF;
        clear_model();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
        chk("rst_test_value", {16'd0, test_value}, 32'd0);
        reset = 1'b1;
        #1;
        chk("ready_after_release", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;

        // Store then load
        access(1'b1, 32'h10, 32'h1234_5678, 4'hF);
        access(1'b0, 32'h10, 32'd0, 4'hF);
        chk("load_0x10_value", rsp_rdata, 32'h1234_5678);

        // test_value follows a store to word 0
        access(1'b1, 32'h0, 32'h0000_ABCD, 4'hF);
        chk("test_value_abcd", {16'd0, test_value}, 32'h0000_ABCD);

        // Misaligned load and store
        access(1'b0, 32'h13, 32'd0, 4'hF);
        access(1'b1, 32'h13, 32'hCAFE_F00D, 4'hF);
        access(1'b0, 32'h10, 32'd0, 4'hF);
        chk("misal_store_no_write", rsp_rdata, 32'h1234_5678);
        chk("misalign_sticky", {31'd0, misalign_err}, 32'd1);

        // Address wrap modulo DEPTH
        access(1'b1, 32'h400, 32'h0000_00AA, 4'hF);
        access(1'b0, 32'h0, 32'd0, 4'hF);
        chk("wrap_load", rsp_rdata, 32'h0000_00AA);

        // Load immediately followed by store to the same word
        access(1'b0, 32'h10, 32'd0, 4'hF);
        access(1'b1, 32'h10, 32'h5555_AAAA, 4'hF);
        access(1'b0, 32'h10, 32'd0, 4'hF);

        // Random traffic
        for (int n = 0; n < 40; n++) begin
            a = ($urandom_range(0, 7) << 2) | ($urandom_range(0, 15) << 10);
            if ($urandom_range(0, 9) == 0) a = a | $urandom_range(1, 3);
            access(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
        end

        // Reset asserted while a store waits
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'hFFFF_FFFF;
        req_be    = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_ready", {31'd0, req_ready}, 32'd0);
        chk("midrst_misalign", {31'd0, misalign_err}, 32'd0);
        chk("midrst_test_value", {16'd0, test_value}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        reset = 1'b1;
        clear_model();
        #1;
        chk("midrst_ready_release", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        access(1'b0, 32'h20, 32'd0, 4'hF);
        chk("midrst_store_dropped", rsp_rdata, 32'd0);

`ifdef DMEM_BYTE_EN_EN
        // Byte-enable merge
        access(1'b1, 32'h40, 32'h1122_3344, 4'b1111);
        access(1'b1, 32'h40, 32'hAABB_CCDD, 4'b0101);
        access(1'b1, 32'h40, 32'h9999_9999, 4'b0000);
        access(1'b0, 32'h40, 32'd0, 4'b0000);
        chk("byte_en_merge", rsp_rdata, 32'h11BB_33DD);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
